// File: rtl/gate_sequencer.sv
// gate_sequencer: streams one column per beat of recurrent/input weights and
// bias into the gate weight RAMs, launches a single gate computation, then
// captures the gate result or raises a sticky timeout flag.
module gate_sequencer #(
    parameter int INPUT_SZ  = 2,
    parameter int HIDDEN_SZ = 16,
    parameter int QN        = 6,
    parameter int QM        = 11,
    parameter int TIMEOUT   = 1024,
    localparam int BITWIDTH        = QN + QM + 1,
    localparam int LAYER_BITWIDTH  = BITWIDTH * HIDDEN_SZ,
    localparam int ADDR_BITWIDTH   = $clog2(HIDDEN_SZ),
    localparam int ADDR_BITWIDTH_X = $clog2(INPUT_SZ)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       colValid,
    output logic                       colReady,
    input  logic [LAYER_BITWIDTH-1:0]  wyCol,
    input  logic [LAYER_BITWIDTH-1:0]  wxCol,
    input  logic [BITWIDTH-1:0]        biasElem,
    output logic [LAYER_BITWIDTH-1:0]  weightMemInput_Y,
    output logic [LAYER_BITWIDTH-1:0]  weightMemInput_X,
    output logic [ADDR_BITWIDTH-1:0]   colAddressWrite_Y,
    output logic [ADDR_BITWIDTH_X-1:0] colAddressWrite_X,
    output logic                       writeEn_Y,
    output logic                       writeEn_X,
    output logic [LAYER_BITWIDTH-1:0]  biasVec,
    output logic                       gateReset,
    output logic                       beginCalc,
    input  logic                       dataReady_gate,
    input  logic [LAYER_BITWIDTH-1:0]  gateOutput,
    output logic [LAYER_BITWIDTH-1:0]  resultOut,
    output logic                       resultValid,
    output logic                       busy,
    output logic                       timeoutErr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } state_t;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_BITWIDTH-1:0] K_LAST   = ADDR_BITWIDTH'(HIDDEN_SZ - 1);
    localparam logic [ADDR_BITWIDTH:0]   X_COLS   = (ADDR_BITWIDTH + 1)'(INPUT_SZ);

    state_t                   state;
    state_t                   next_state;
    logic [ADDR_BITWIDTH-1:0] k;
    logic [CNT_W-1:0]         wait_cnt;
    logic                     accept;
    logic                     last_col;
    logic                     x_col;
    logic                     timed_out;

    assign accept    = (state == LOAD) && colValid && colReady;
    assign last_col  = (k == K_LAST);
    assign x_col     = ({1'b0, k} < X_COLS);
    assign timed_out = (wait_cnt == CNT_LAST);

    // State register.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of block ordering.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; the column counter never wraps, the last beat exits LOAD.
    always_comb begin
        // NOTE: default assignment first so no path leaves next_state unassigned
        // (otherwise a latch is inferred).
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LOAD;
            LOAD:    if (accept && last_col) next_state = START;
            START:   next_state = WAIT;
            WAIT:    if (dataReady_gate || timed_out) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Registered outputs, column counter, wait timer and captured result.
    always_ff @(posedge clock) begin
        // NOTE: the wide data registers (weights, bias, result) are ordinary
        // flops, not a RAM array, so clearing them on reset is cheap and keeps
        // every output at a known value.
        if (reset) begin
            k                 <= '0;
            wait_cnt          <= '0;
            colReady          <= 1'b0;
            busy              <= 1'b0;
            beginCalc         <= 1'b0;
            gateReset         <= 1'b1;
            writeEn_Y         <= 1'b0;
            writeEn_X         <= 1'b0;
            resultValid       <= 1'b0;
            timeoutErr        <= 1'b0;
            colAddressWrite_Y <= '0;
            colAddressWrite_X <= '0;
            weightMemInput_Y  <= '0;
            weightMemInput_X  <= '0;
            biasVec           <= '0;
            resultOut         <= '0;
        end else begin
            // Status outputs track the state being entered so they line up with it.
            colReady    <= (next_state == LOAD);
            busy        <= (next_state != IDLE);
            beginCalc   <= (next_state == START);
            gateReset   <= (next_state == IDLE) || (next_state == LOAD);
            writeEn_Y   <= accept;
            writeEn_X   <= accept && x_col;
            resultValid <= 1'b0;

            if (state == IDLE && start) begin
                k          <= '0;
                timeoutErr <= 1'b0;
            end

            if (accept) begin
                colAddressWrite_Y                 <= k;
                weightMemInput_Y                  <= wyCol;
                biasVec[k*BITWIDTH +: BITWIDTH]   <= biasElem;
                if (x_col) begin
                    colAddressWrite_X <= k[ADDR_BITWIDTH_X-1:0];
                    weightMemInput_X  <= wxCol;
                end
                if (!last_col) begin
                    k <= k + ADDR_BITWIDTH'(1);
                end
            end

            if (state == START) begin
                wait_cnt <= '0;
            end

            // A result arriving on the final wait cycle still wins over the timeout.
            if (state == WAIT) begin
                if (dataReady_gate) begin
                    resultOut   <= gateOutput;
                    resultValid <= 1'b1;
                end else if (timed_out) begin
                    timeoutErr <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_gate_sequencer.sv
// tb_gate_sequencer: randomized scoreboard bench. The driver pushes expected
// RAM writes and results into queues; a monitor pops them when the DUT strobes.
// A second instance with TIMEOUT=8 shares the inputs for the timeout case.
module tb_gate_sequencer;

    localparam int HIDDEN_SZ = 16;
    localparam int INPUT_SZ  = 2;
    localparam int BW        = 18;
    localparam int LW        = BW * HIDDEN_SZ;

    typedef struct packed {
        logic [3:0]    addr;
        logic [LW-1:0] data;
    } wr_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          colValid;
    logic [LW-1:0] wyCol;
    logic [LW-1:0] wxCol;
    logic [BW-1:0] biasElem;
    logic          dataReady_gate;
    logic [LW-1:0] gateOutput;

    logic          colReady, writeEn_Y, writeEn_X, gateReset, beginCalc;
    logic          resultValid, busy, timeoutErr;
    logic [LW-1:0] weightMemInput_Y, weightMemInput_X, biasVec, resultOut;
    logic [3:0]    colAddressWrite_Y;
    logic [0:0]    colAddressWrite_X;

    logic          t_colReady, t_writeEn_Y, t_writeEn_X, t_gateReset, t_beginCalc;
    logic          t_resultValid, t_busy, t_timeoutErr;
    logic [LW-1:0] t_weightMemInput_Y, t_weightMemInput_X, t_biasVec, t_resultOut;
    logic [3:0]    t_colAddressWrite_Y;
    logic [0:0]    t_colAddressWrite_X;

    gate_sequencer dut (
        .clock(clock), .reset(reset), .start(start),
        .colValid(colValid), .colReady(colReady),
        .wyCol(wyCol), .wxCol(wxCol), .biasElem(biasElem),
        .weightMemInput_Y(weightMemInput_Y), .weightMemInput_X(weightMemInput_X),
        .colAddressWrite_Y(colAddressWrite_Y), .colAddressWrite_X(colAddressWrite_X),
        .writeEn_Y(writeEn_Y), .writeEn_X(writeEn_X),
        .biasVec(biasVec), .gateReset(gateReset), .beginCalc(beginCalc),
        .dataReady_gate(dataReady_gate), .gateOutput(gateOutput),
        .resultOut(resultOut), .resultValid(resultValid),
        .busy(busy), .timeoutErr(timeoutErr)
    );

    gate_sequencer #(.TIMEOUT(8)) dut_t (
        .clock(clock), .reset(reset), .start(start),
        .colValid(colValid), .colReady(t_colReady),
        .wyCol(wyCol), .wxCol(wxCol), .biasElem(biasElem),
        .weightMemInput_Y(t_weightMemInput_Y), .weightMemInput_X(t_weightMemInput_X),
        .colAddressWrite_Y(t_colAddressWrite_Y), .colAddressWrite_X(t_colAddressWrite_X),
        .writeEn_Y(t_writeEn_Y), .writeEn_X(t_writeEn_X),
        .biasVec(t_biasVec), .gateReset(t_gateReset), .beginCalc(t_beginCalc),
        .dataReady_gate(dataReady_gate), .gateOutput(gateOutput),
        .resultOut(t_resultOut), .resultValid(t_resultValid),
        .busy(t_busy), .timeoutErr(t_timeoutErr)
    );

    always #5 clock = ~clock;

    wr_t           wy_q[$];
    wr_t           wx_q[$];
    logic [LW-1:0] res_q[$];
    logic [BW-1:0] bias_m[HIDDEN_SZ];
    int            n_tests     = 0;
    int            n_fail      = 0;
    int            rv_count    = 0;
    int            t_rv_count  = 0;
    int            n_results   = 0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes a write or result.
    initial begin : monitor
        wr_t e;
        forever begin
            @(negedge clock);
            if (writeEn_Y) begin
                if (wy_q.size() == 0) check("unexpected Y write", LW'(1), LW'(0));
                else begin
                    e = wy_q.pop_front();
                    check("Y write addr", LW'(colAddressWrite_Y), LW'(e.addr));
                    check("Y write data", weightMemInput_Y, e.data);
                end
            end
            if (writeEn_X) begin
                if (wx_q.size() == 0) check("unexpected X write", LW'(1), LW'(0));
                else begin
                    e = wx_q.pop_front();
                    check("X write addr", LW'(colAddressWrite_X), LW'(e.addr));
                    check("X write data", weightMemInput_X, e.data);
                end
            end
            if (resultValid) begin
                rv_count++;
                if (res_q.size() == 0) check("unexpected resultValid", LW'(1), LW'(0));
                else check("resultOut", resultOut, res_q.pop_front());
            end
            if (t_resultValid) t_rv_count++;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_state(input string tag);
        check({tag, " busy"}, LW'(busy), LW'(0));
        check({tag, " colReady"}, LW'(colReady), LW'(0));
        check({tag, " gateReset"}, LW'(gateReset), LW'(1));
        check({tag, " strobes"}, LW'({writeEn_Y, writeEn_X, beginCalc, resultValid, timeoutErr}), LW'(0));
        check({tag, " addresses"}, LW'({colAddressWrite_Y, colAddressWrite_X}), LW'(0));
        check({tag, " weight data"}, weightMemInput_Y | weightMemInput_X, LW'(0));
        check({tag, " biasVec"}, biasVec, LW'(0));
        check({tag, " resultOut"}, resultOut, LW'(0));
    endtask

    // Issues start from IDLE; LOAD must be entered on the very next cycle.
    task automatic begin_run(input bit hold);
        start = 1'b1;
        step();
        check("LOAD entry colReady", LW'(colReady), LW'(1));
        check("LOAD entry busy/gateReset", LW'({busy, gateReset}), LW'(2'b11));
        check("timeoutErr cleared by start", LW'({timeoutErr, t_timeoutErr}), LW'(0));
        if (!hold) start = 1'b0;
    endtask

    // Presents beats until n_beats have been accepted; stall gives valid 1,0,0,...
    task automatic load(input int n_beats, input bit stall, input bit rnd, input bit stray);
        int       k;
        int       cyc;
        bit       early;
        bit       stray_done;
        logic [31:0] r1, r2;
        k = 0; cyc = 0; early = 1'b0; stray_done = 1'b0;
        while (k < n_beats && cyc < 400) begin
            colValid = stall ? (cyc % 3 == 0) : 1'b1;
            for (int e = 0; e < HIDDEN_SZ; e++) begin
                r1 = $urandom; r2 = $urandom;
                wyCol[e*BW +: BW] = rnd ? r1[BW-1:0] : BW'(k);
                wxCol[e*BW +: BW] = rnd ? r2[BW-1:0] : BW'(32'h100 + k);
            end
            r1 = $urandom;
            biasElem = rnd ? r1[BW-1:0] : BW'(k);
            dataReady_gate = 1'b0;
            if (stray && k == 3 && !stray_done) begin
                dataReady_gate = 1'b1;
                r2 = $urandom;
                gateOutput = {HIDDEN_SZ{r2[BW-1:0]}};
                stray_done = 1'b1;
            end
            if (beginCalc) early = 1'b1;
            if (colValid && colReady) begin
                wy_q.push_back('{addr: 4'(k), data: wyCol});
                if (k < INPUT_SZ) wx_q.push_back('{addr: 4'(k), data: wxCol});
                bias_m[k] = biasElem;
                k++;
            end
            step();
            cyc++;
        end
        colValid = 1'b0;
        dataReady_gate = 1'b0;
        check("beats accepted within budget", LW'(k), LW'(n_beats));
        check("no beginCalc during LOAD", LW'(early), LW'(0));
    endtask

    // Called in the START cycle. delay>0: result delay cycles after beginCalc.
    // delay<0: no result; both instances must time out.
    task automatic finish(input int delay);
        logic [LW-1:0] exp_bias;
        logic [LW-1:0] g;
        logic [31:0]   r;
        int            n, tn, mn;
        for (int e = 0; e < HIDDEN_SZ; e++) exp_bias[e*BW +: BW] = bias_m[e];
        check("START beginCalc", LW'(beginCalc), LW'(1));
        check("START colReady/gateReset", LW'({colReady, gateReset}), LW'(0));
        check("START busy", LW'(busy), LW'(1));
        check("biasVec", biasVec, exp_bias);
        step();
        check("beginCalc single cycle", LW'(beginCalc), LW'(0));
        check("all columns written", LW'(wy_q.size() + wx_q.size()), LW'(0));
        if (delay > 0) begin
            for (int i = 1; i < delay; i++) step();
            for (int e = 0; e < HIDDEN_SZ; e++) begin
                r = $urandom;
                g[e*BW +: BW] = r[BW-1:0];
            end
            gateOutput = g;
            dataReady_gate = 1'b1;
            res_q.push_back(g);
            n_results++;
            step();
            dataReady_gate = 1'b0;
            check("IDLE after result", LW'({busy, timeoutErr}), LW'(0));
        end else begin
            n = 0; tn = -1; mn = -1;
            while (mn < 0 && n < 1200) begin
                step();
                n++;
                if (tn < 0 && !t_busy) begin
                    tn = n;
                    check("timeoutErr on timeout return", LW'(t_timeoutErr), LW'(1));
                    check("resultOut unchanged on timeout", t_resultOut, LW'(0));
                end
                if (!busy) mn = n;
            end
            check("WAIT length TIMEOUT=8", LW'(tn), LW'(8));
            check("WAIT length TIMEOUT=1024", LW'(mn), LW'(1024));
            check("timeoutErr sticky", LW'({timeoutErr, t_timeoutErr}), LW'(2'b11));
        end
    endtask

    initial begin : driver
        reset = 1'b1; start = 1'b0; colValid = 1'b0; wyCol = '0; wxCol = '0;
        biasElem = '0; dataReady_gate = 1'b0; gateOutput = '0;
        repeat (3) step();
        check_reset_state("reset");
        reset = 1'b0;
        step();

        // Nominal run with the fixed data pattern.
        begin_run(1'b0);
        load(16, 1'b0, 1'b0, 1'b0);
        finish(20);

        // Stalled load.
        begin_run(1'b0);
        load(16, 1'b1, 1'b1, 1'b0);
        finish(25);

        // Reset mid-LOAD after beat 5, then a fresh run from column 0.
        begin_run(1'b0);
        load(5, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        step();
        check_reset_state("abort");
        reset = 1'b0;
        step();
        begin_run(1'b0);
        load(16, 1'b0, 1'b1, 1'b0);
        finish(12);

        // Timeout: no result ever arrives.
        begin_run(1'b0);
        load(16, 1'b0, 1'b1, 1'b0);
        finish(-1);

        // start held through a run with a stray result pulse in LOAD; back-to-back restart.
        begin_run(1'b1);
        load(16, 1'b0, 1'b1, 1'b1);
        finish(20);
        begin_run(1'b0);
        load(16, 1'b0, 1'b1, 1'b0);
        finish(15);

        // Randomized runs.
        for (int r = 0; r < 4; r++) begin
            begin_run(1'b0);
            load(16, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            finish(int'($urandom_range(10, 40)));
        end

        repeat (3) step();
        check("resultValid pulse count", LW'(rv_count), LW'(n_results));
        check("no resultValid on timeout instance", LW'(t_rv_count), LW'(0));
        check("scoreboard drained", LW'(wy_q.size() + wx_q.size() + res_q.size()), LW'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
